se_target_select: RTL and testbench

- Per-pixel front end of the special-effects path.
- Takes the colors, opacity and priorities of the four BG layers, the OBJ layer and the backdrop.
- Resolves the topmost and second-topmost visible layers and applies the BLDCNT target/mode rules.
- Delivers first/second 15-bit colors plus effect control to the per-channel color blenders.
- Sits between layer rendering and the blender.
- Two-stage pipeline with a valid/ready handshake on both sides.

---
 rtl/se_target_select.sv | 180 ++++++++++++++++++
 tb/tb_se_target_select.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/se_target_select.sv
// Special-effects front end: resolves the top two visible layers per pixel and
// applies the BLDCNT target/mode rules, in a two-stage valid/ready pipeline.
module se_target_select #(
  parameter int unsigned LAT = 2
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [59:0] bg_color,
  input  logic [3:0]  bg_opaque,
  input  logic [7:0]  bg_prio,
  input  logic [14:0] obj_color,
  input  logic        obj_opaque,
  input  logic [1:0]  obj_prio,
  input  logic        obj_semitrans,
  input  logic [14:0] backdrop,
  input  logic [15:0] bldcnt,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [14:0] first_color,
  output logic [14:0] second_color,
  output logic        effect_en,
  output logic [1:0]  blend_mode
);

  if (LAT != 2) begin : g_lat_check
    $error("se_target_select supports only LAT=2");
  end

  typedef enum logic [2:0] {
    L_BG0 = 3'd0, L_BG1 = 3'd1, L_BG2 = 3'd2, L_BG3 = 3'd3,
    L_OBJ = 3'd4, L_BD  = 3'd5
  } layer_t;

  logic        s1_valid, s2_valid;
  logic        s1_adv, s2_adv;
  logic [59:0] s1_bg_color;
  logic [14:0] s1_obj_color, s1_backdrop;
  logic        s1_semi;
  logic [13:0] s1_bldcnt;
  layer_t      s1_l1, s1_l2;
  logic [1:0]  unused_bldcnt;

  assign unused_bldcnt = bldcnt[15:14];

  assign s2_adv   = !s2_valid || out_ready;
  assign s1_adv   = !s1_valid || s2_adv;
  assign in_ready = s1_adv;
  assign out_valid = s2_valid;

  // Sort key = {priority, rank}: OBJ ranks 0, BGn ranks n+1, so ties resolve
  // with a plain unsigned compare.
  layer_t     best1, best2;
  logic [4:0] key1, key2, key;
  logic       present;

  always_comb begin
    best1   = L_BD;
    best2   = L_BD;
    key1    = '1;
    key2    = '1;
    key     = '0;
    present = 1'b0;
    for (int unsigned i = 0; i < 5; i++) begin
      if (i < 4) begin
        present = bg_opaque[i];
        key     = {bg_prio[2*i +: 2], 3'(i + 1)};
      end else begin
        present = obj_opaque;
        key     = {obj_prio, 3'd0};
      end
      if (present) begin
        if (key < key1) begin
          best2 = best1;
          key2  = key1;
          best1 = layer_t'(3'(i));
          key1  = key;
        end else if (key < key2) begin
          best2 = layer_t'(3'(i));
          key2  = key;
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid     <= 1'b0;
      s1_bg_color  <= '0;
      s1_obj_color <= '0;
      s1_backdrop  <= '0;
      s1_semi      <= 1'b0;
      s1_bldcnt    <= '0;
      s1_l1        <= L_BD;
      s1_l2        <= L_BD;
    end else if (s1_adv) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_bg_color  <= bg_color;
        s1_obj_color <= obj_color;
        s1_backdrop  <= backdrop;
        s1_semi      <= obj_semitrans;
        s1_bldcnt    <= bldcnt[13:0];
        s1_l1        <= best1;
        s1_l2        <= best2;
      end
    end
  end

  logic [14:0] l1_color, l2_color;
  logic [5:0]  first_t, second_t;
  logic [1:0]  mode;
  logic        alpha, nxt_effect;
  logic [1:0]  nxt_mode;

  always_comb begin
    case (s1_l1)
      L_BG0:   l1_color = s1_bg_color[14:0];
      L_BG1:   l1_color = s1_bg_color[29:15];
      L_BG2:   l1_color = s1_bg_color[44:30];
      L_BG3:   l1_color = s1_bg_color[59:45];
      L_OBJ:   l1_color = s1_obj_color;
      default: l1_color = s1_backdrop;
    endcase
    case (s1_l2)
      L_BG0:   l2_color = s1_bg_color[14:0];
      L_BG1:   l2_color = s1_bg_color[29:15];
      L_BG2:   l2_color = s1_bg_color[44:30];
      L_BG3:   l2_color = s1_bg_color[59:45];
      L_OBJ:   l2_color = s1_obj_color;
      default: l2_color = s1_backdrop;
    endcase
  end

  always_comb begin
    first_t    = s1_bldcnt[5:0];
    second_t   = s1_bldcnt[13:8];
    mode       = s1_bldcnt[7:6];
    alpha      = 1'b0;
    nxt_effect = 1'b0;
    nxt_mode   = 2'b00;
    if (s1_l1 == L_OBJ && s1_semi && second_t[s1_l2]) begin
      alpha = 1'b1;
    end else begin
      case (mode)
        2'b01:   alpha = first_t[s1_l1] && second_t[s1_l2];
        2'b10,
        2'b11: begin
          nxt_effect = first_t[s1_l1];
          nxt_mode   = first_t[s1_l1] ? mode : 2'b00;
        end
        default: ;
      endcase
    end
    if (alpha) begin
      nxt_effect = 1'b1;
      nxt_mode   = 2'b01;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s2_valid     <= 1'b0;
      first_color  <= '0;
      second_color <= '0;
      effect_en    <= 1'b0;
      blend_mode   <= 2'b00;
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        first_color  <= l1_color;
        second_color <= alpha ? l2_color : 15'd0;
        effect_en    <= nxt_effect;
        blend_mode   <= nxt_mode;
      end
    end
  end

endmodule

// File: tb/tb_se_target_select.sv
// Directed self-checking bench for se_target_select: layer ordering, effect
// rules, latency, back-pressure and mid-flight reset.
module tb_se_target_select;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [59:0] bg_color = '0;
  logic [3:0]  bg_opaque = '0;
  logic [7:0]  bg_prio = '0;
  logic [14:0] obj_color = '0;
  logic        obj_opaque = 1'b0;
  logic [1:0]  obj_prio = '0;
  logic        obj_semitrans = 1'b0;
  logic [14:0] backdrop = '0;
  logic [15:0] bldcnt = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [14:0] first_color, second_color;
  logic        effect_en;
  logic [1:0]  blend_mode;

  int vectors = 0;
  int miscompares = 0;

  se_target_select #(.LAT(2)) dut (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .bg_color(bg_color), .bg_opaque(bg_opaque), .bg_prio(bg_prio),
    .obj_color(obj_color), .obj_opaque(obj_opaque), .obj_prio(obj_prio),
    .obj_semitrans(obj_semitrans), .backdrop(backdrop), .bldcnt(bldcnt),
    .out_valid(out_valid), .out_ready(out_ready), .first_color(first_color),
    .second_color(second_color), .effect_en(effect_en), .blend_mode(blend_mode)
  );

  always #5 clock = ~clock;

  logic        r_rdy, r_v1, r_v2, r_eff;
  logic [14:0] r_first, r_second;
  logic [1:0]  r_mode;

  task automatic clear_layers();
    bg_color = {15'h4444, 15'h3333, 15'h0222, 15'h0011};
    bg_opaque = '0; bg_prio = '0;
    obj_color = 15'h1555; obj_opaque = 1'b0; obj_prio = '0; obj_semitrans = 1'b0;
    backdrop = 15'h2A5A; bldcnt = '0;
  endtask

  // Presents one pixel with out_ready high; samples 1 and 2 cycles after accept.
  task automatic run_pixel();
    out_ready = 1'b1;
    in_valid = 1'b1;
    #1 r_rdy = in_ready;
    @(posedge clock); #1;
    in_valid = 1'b0;
    r_v1 = out_valid;
    @(posedge clock); #1;
    r_v2 = out_valid; r_first = first_color; r_second = second_color;
    r_eff = effect_en; r_mode = blend_mode;
  endtask

  task automatic test_reset();
    #3;
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    vectors++; if ({first_color, second_color, effect_en, blend_mode} !== 33'd0) begin
      miscompares++; $display("FAIL reset_outputs got %h/%h/%b/%b exp 0", first_color, second_color, effect_en, blend_mode); end
    @(posedge clock); #1;
    reset_n = 1'b1;
    #1;
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
  endtask

  task automatic test_priority();
    clear_layers();
    bg_opaque = 4'b1111; bg_prio = 8'b11_11_01_10; obj_opaque = 1'b1; obj_prio = 2'd1;
    run_pixel();
    vectors++; if (r_rdy !== 1'b1) begin miscompares++; $display("FAIL prio_in_ready got %b exp 1", r_rdy); end
    vectors++; if (r_v1 !== 1'b0) begin miscompares++; $display("FAIL prio_latency1 got %b exp 0", r_v1); end
    vectors++; if (r_v2 !== 1'b1) begin miscompares++; $display("FAIL prio_latency2 got %b exp 1", r_v2); end
    vectors++; if (r_first !== 15'h1555) begin miscompares++; $display("FAIL prio_first got %h exp 1555", r_first); end
    vectors++; if ({r_eff, r_mode, r_second} !== 18'd0) begin
      miscompares++; $display("FAIL prio_noeffect got %b/%b/%h exp 0/00/0000", r_eff, r_mode, r_second); end
    bldcnt = 16'h0250;  // OBJ first, mode alpha, BG1 second: BG1 must be L2
    run_pixel();
    vectors++; if ({r_first, r_second, r_eff, r_mode} !== {15'h1555, 15'h0222, 1'b1, 2'b01}) begin
      miscompares++; $display("FAIL prio_l2 got %h/%h/%b/%b exp 1555/0222/1/01", r_first, r_second, r_eff, r_mode); end
    bg_opaque = 4'b1011; bg_prio = 8'h31; obj_opaque = 1'b0; bldcnt = 16'h0842;
    run_pixel();
    vectors++; if ({r_first, r_second, r_eff, r_mode} !== {15'h0222, 15'h4444, 1'b1, 2'b01}) begin
      miscompares++; $display("FAIL bg_tie got %h/%h/%b/%b exp 0222/4444/1/01", r_first, r_second, r_eff, r_mode); end
  endtask

  task automatic test_alpha();
    clear_layers();
    bg_color[44:30] = 15'h7C00; bg_opaque = 4'b0100; bg_prio = 8'h20;
    backdrop = 15'h001F; bldcnt = 16'h2044;
    run_pixel();
    vectors++; if ({r_first, r_second, r_eff, r_mode} !== {15'h7C00, 15'h001F, 1'b1, 2'b01}) begin
      miscompares++; $display("FAIL alpha got %h/%h/%b/%b exp 7c00/001f/1/01", r_first, r_second, r_eff, r_mode); end
    bldcnt = 16'h2040;  // BG2 not a first target
    run_pixel();
    vectors++; if ({r_first, r_second, r_eff, r_mode} !== {15'h7C00, 15'h0000, 1'b0, 2'b00}) begin
      miscompares++; $display("FAIL alpha_nofirst got %h/%h/%b/%b exp 7c00/0000/0/00", r_first, r_second, r_eff, r_mode); end
  endtask

  task automatic test_semitrans();
    clear_layers();
    obj_opaque = 1'b1; obj_prio = 2'd0; obj_semitrans = 1'b1;
    bg_opaque = 4'b0001; bg_prio = 8'h00; bldcnt = 16'h0100;
    run_pixel();
    vectors++; if ({r_first, r_second, r_eff, r_mode} !== {15'h1555, 15'h0011, 1'b1, 2'b01}) begin
      miscompares++; $display("FAIL semi_alpha got %h/%h/%b/%b exp 1555/0011/1/01", r_first, r_second, r_eff, r_mode); end
    bldcnt = 16'h0000;
    run_pixel();
    vectors++; if ({r_first, r_second, r_eff, r_mode} !== {15'h1555, 15'h0000, 1'b0, 2'b00}) begin
      miscompares++; $display("FAIL semi_off got %h/%h/%b/%b exp 1555/0000/0/00", r_first, r_second, r_eff, r_mode); end
  endtask

  task automatic test_darken();
    clear_layers();
    bldcnt = 16'h00E0;
    run_pixel();
    vectors++; if ({r_first, r_second, r_eff, r_mode} !== {15'h2A5A, 15'h0000, 1'b1, 2'b11}) begin
      miscompares++; $display("FAIL darken got %h/%h/%b/%b exp 2a5a/0000/1/11", r_first, r_second, r_eff, r_mode); end
    bldcnt = 16'h00C0;
    run_pixel();
    vectors++; if ({r_first, r_second, r_eff, r_mode} !== {15'h2A5A, 15'h0000, 1'b0, 2'b00}) begin
      miscompares++; $display("FAIL darken_off got %h/%h/%b/%b exp 2a5a/0000/0/00", r_first, r_second, r_eff, r_mode); end
    bldcnt = 16'h00A0;
    run_pixel();
    vectors++; if ({r_first, r_eff, r_mode} !== {15'h2A5A, 1'b1, 2'b10}) begin
      miscompares++; $display("FAIL brighten got %h/%b/%b exp 2a5a/1/10", r_first, r_eff, r_mode); end
  endtask

  task automatic test_back_to_back();
    logic [3:0]  pat;
    int          sent, recv;
    logic        held_valid, acc_in, acc_out;
    logic [14:0] held, got;
    pat = 4'b1001; sent = 0; recv = 0; held_valid = 1'b0; held = '0;
    clear_layers();
    bg_opaque = 4'b0001;
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clock); #1;
    for (int c = 0; c < 40 && recv < 6; c++) begin
      out_ready = pat[c % 4];
      in_valid = (sent < 6);
      bg_color[14:0] = 15'(sent + 1);
      #1;
      if (held_valid) begin
        vectors++;
        if (out_valid !== 1'b1 || first_color !== held) begin
          miscompares++; $display("FAIL bp_hold got %b/%h exp 1/%h", out_valid, first_color, held); end
      end
      if (c == 1) begin
        vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL bp_ready_c1 got %b exp 1", in_ready); end
      end
      if (c == 2) begin
        vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL bp_ready_c2 got %b exp 0", in_ready); end
      end
      acc_in = in_valid && in_ready;
      acc_out = out_valid && out_ready;
      held_valid = out_valid && !out_ready;
      held = first_color;
      got = first_color;
      @(posedge clock); #1;
      if (acc_out) begin
        vectors++;
        if (got !== 15'(recv + 1)) begin
          miscompares++; $display("FAIL bp_order got %h exp %h", got, 15'(recv + 1)); end
        recv++;
      end
      if (acc_in) sent++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    vectors++; if (recv != 6 || sent != 6) begin
      miscompares++; $display("FAIL bp_count got %0d/%0d exp 6/6", recv, sent); end
    #1;
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL bp_drained got %b exp 0", out_valid); end
  endtask

  task automatic test_reset_midflight();
    clear_layers();
    bg_opaque = 4'b0001; out_ready = 1'b1; in_valid = 1'b1;
    @(posedge clock); #1;
    bg_color[14:0] = 15'h0033;
    @(posedge clock); #1;
    in_valid = 1'b0; out_ready = 1'b0;
    vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL mid_pre got %b exp 1", out_valid); end
    reset_n = 1'b0;
    #1;
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL mid_valid got %b exp 0", out_valid); end
    vectors++; if ({first_color, second_color, effect_en, blend_mode} !== 33'd0) begin
      miscompares++; $display("FAIL mid_outputs got %h/%h/%b/%b exp 0", first_color, second_color, effect_en, blend_mode); end
    @(posedge clock); #1;
    reset_n = 1'b1; out_ready = 1'b1;
    #1;
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL mid_in_ready got %b exp 1", in_ready); end
    clear_layers();
    bldcnt = 16'h00E0;
    run_pixel();
    vectors++; if ({r_v1, r_v2} !== 2'b01) begin miscompares++; $display("FAIL mid_latency got %b%b exp 01", r_v1, r_v2); end
    vectors++; if ({r_first, r_eff, r_mode} !== {15'h2A5A, 1'b1, 2'b11}) begin
      miscompares++; $display("FAIL mid_result got %h/%b/%b exp 2a5a/1/11", r_first, r_eff, r_mode); end
  endtask

  initial begin
    clear_layers();
    test_reset();
    test_priority();
    test_alpha();
    test_semitrans();
    test_darken();
    test_back_to_back();
    test_reset_midflight();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
